// File: rtl/bnn_pkg.sv
// Shared definitions for the Bayesian network Monte-Carlo sequencer.
// BNN_MC_CLASS_EN adds the ARGMAX state to the state encoding.
package bnn_pkg;

  localparam int DATA_W = 20;
  localparam int N_OUT  = 9;
  localparam int N_IN   = 9;
  localparam int BUS_W  = DATA_W * N_OUT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_AVG    = 3'd3,
`ifdef BNN_MC_CLASS_EN
    ST_ARGMAX = 3'd4,
`endif
    ST_DONE   = 3'd5
  } state_t;

  // Lane k of a packed output bus, as a signed sample.
  function automatic logic signed [DATA_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                          input int k);
    return $signed(bus[k*DATA_W +: DATA_W]);
  endfunction

endpackage

// File: rtl/bnn_mc_accum.sv
// Single-lane signed sample accumulator with clear, enable and mean output.
// The accumulator carries SHIFT guard bits, so 2^SHIFT samples cannot overflow.
module bnn_mc_accum #(
  parameter int DATA_W = 20,
  parameter int SHIFT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] mean
);

  localparam int ACC_W = DATA_W + SHIFT;

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] din_ext_s;

  assign din_ext_s = {{SHIFT{din[DATA_W-1]}}, din};

  // Dropping the SHIFT low bits is an arithmetic shift (floor), and the
  // remaining DATA_W bits are exactly the truncated mean.
  assign mean = acc_r[ACC_W-1:SHIFT];

  // Clear on a new inference, otherwise add one sign-extended sample per enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + din_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/bnn_mc_sequencer.sv
// Monte-Carlo inference sequencer: holds X on the datapath, lets the epsilon
// sampler run, averages 2^LOG2_SAMPLES output vectors and returns the mean.
// Optional feature macro: BNN_MC_CLASS_EN (argmax over the nine means).
module bnn_mc_sequencer
  import bnn_pkg::*;
#(
  parameter int LOG2_SAMPLES  = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x_in,
  input  logic             abort,
  output logic [N_IN-1:0]  x_out,
  output logic             eps_en,
  input  logic [BUS_W-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] y_mean,
  output logic             busy
`ifdef BNN_MC_CLASS_EN
  ,
  output logic [3:0]       class_idx
`endif
);

  localparam int SAMPLES = 1 << LOG2_SAMPLES;
  localparam logic [LOG2_SAMPLES:0] SAMP_LAST = (LOG2_SAMPLES+1)'(SAMPLES - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t                state_r;
  logic [N_IN-1:0]       x_r;
  logic                  eps_en_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic [BUS_W-1:0]      y_mean_r;
  logic [BUS_W-1:0]      mean_bus_s;
  logic [3:0]            settle_cnt_r;
  logic [LOG2_SAMPLES:0] samp_cnt_r;
  logic                  accept_s;
  logic                  active_s;
  logic                  abort_s;
  logic                  acc_clr_s;
  logic                  acc_en_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign x_out     = x_r;
  assign eps_en    = eps_en_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign y_mean    = y_mean_r;

  assign accept_s  = (state_r == ST_IDLE) && in_valid;
  assign abort_s   = abort && active_s;
  assign acc_clr_s = accept_s || abort_s;
  assign acc_en_s  = (state_r == ST_ACCUM);

  // States in which an abort cancels the inference.
  always_comb begin
    active_s = 1'b0;
    case (state_r)
      ST_SETTLE, ST_ACCUM, ST_AVG: active_s = 1'b1;
`ifdef BNN_MC_CLASS_EN
      ST_ARGMAX: active_s = 1'b1;
`endif
      default: active_s = 1'b0;
    endcase
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    logic [DATA_W-1:0] mean_s;

    bnn_mc_accum #(
      .DATA_W (DATA_W),
      .SHIFT  (LOG2_SAMPLES)
    ) u_accum (
      .clk  (clk),
      .rst  (rst),
      .clr  (acc_clr_s),
      .en   (acc_en_s),
      .din  (lane_slice(y_in, g)),
      .mean (mean_s)
    );

    assign mean_bus_s[g*DATA_W +: DATA_W] = mean_s;
  end

`ifdef BNN_MC_CLASS_EN
  logic [3:0]               scan_cnt_r;
  logic [3:0]               best_idx_r;
  logic signed [DATA_W-1:0] best_val_r;
  logic [3:0]               class_idx_r;
  logic signed [DATA_W-1:0] cand_s;
  logic                     cand_gt_s;

  // Strictly-greater compare so a tie keeps the lower index.
  assign cand_s    = lane_slice(y_mean_r, int'(scan_cnt_r));
  assign cand_gt_s = (cand_s > best_val_r);
  assign class_idx = class_idx_r;
`endif

  // Inference control: state, held X, counters, mean register and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      x_r          <= '0;
      eps_en_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      y_mean_r     <= '0;
      settle_cnt_r <= 4'd0;
      samp_cnt_r   <= '0;
`ifdef BNN_MC_CLASS_EN
      scan_cnt_r   <= 4'd0;
      best_idx_r   <= 4'd0;
      best_val_r   <= '0;
      class_idx_r  <= 4'd0;
`endif
    end else if (abort_s) begin
      state_r      <= ST_IDLE;
      eps_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      settle_cnt_r <= 4'd0;
      samp_cnt_r   <= '0;
`ifdef BNN_MC_CLASS_EN
      scan_cnt_r   <= 4'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r          <= x_in;
            settle_cnt_r <= SETTLE_LOAD;
            eps_en_r     <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == 4'd1) begin
            settle_cnt_r <= 4'd0;
            samp_cnt_r   <= '0;
            state_r      <= ST_ACCUM;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        ST_ACCUM: begin
          if (samp_cnt_r == SAMP_LAST) begin
            samp_cnt_r <= '0;
            eps_en_r   <= 1'b0;
            state_r    <= ST_AVG;
          end else begin
            samp_cnt_r <= samp_cnt_r + 1'b1;
          end
        end
        ST_AVG: begin
          y_mean_r <= mean_bus_s;
`ifdef BNN_MC_CLASS_EN
          scan_cnt_r <= 4'd0;
          state_r    <= ST_ARGMAX;
`else
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
`endif
        end
`ifdef BNN_MC_CLASS_EN
        ST_ARGMAX: begin
          if ((scan_cnt_r == 4'd0) || cand_gt_s) begin
            best_val_r <= cand_s;
            best_idx_r <= scan_cnt_r;
          end
          if (scan_cnt_r == 4'd8) begin
            class_idx_r <= cand_gt_s ? 4'd8 : best_idx_r;
            scan_cnt_r  <= 4'd0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            scan_cnt_r <= scan_cnt_r + 4'd1;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          eps_en_r    <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
